program_memory_loader: RTL
==========================

Name: program_memory_loader

Overview:
Fills the instruction memory of the single-cycle processor from an 8-bit byte stream supplied by a host or UART receiver. It is the write-side counterpart of the program ROM read path. Incoming bytes are packed little-endian into DATA_WIDTH-bit words, and each word is written to sequential word addresses starting at 0. A done flag is raised once the requested word count has been written.

Parameters:
DATA_WIDTH, 32, instruction word width; must be a multiple of 8
ADDR_WIDTH, 8, word-address width; memory depth = 2^ADDR_WIDTH words

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset
start_i  input  1  begin a load; sampled only in IDLE
word_count_i  input  ADDR_WIDTH+1  number of words to load; latched on accepted start
byte_i  input  8  stream byte
byte_valid_i  input  1  byte_i holds a valid byte
byte_ready_o  output  1  loader can accept a byte; a transfer occurs when valid & ready at a rising edge
mem_we_o  output  1  memory write enable, one-cycle pulse per word
mem_addr_o  output  ADDR_WIDTH  word address of the write
mem_data_o  output  DATA_WIDTH  assembled word
busy_o  output  1  load in progress
done_o  output  1  one-cycle pulse when the load ends
error_o  output  1  qualifies done_o: the request was rejected

Behaviour:
- Reset (synchronous, active-high): state = IDLE; all outputs 0; byte counter, word address and word register cleared. Reset overrides every other input.
- States: IDLE, COLLECT, WRITE, DONE. All outputs are registered.
- IDLE:
  - byte_ready_o = 0, busy_o = 0.
  - On start_i = 1:
    - word_count_i == 0: go to DONE with error_o = 0.
    - word_count_i > 2^ADDR_WIDTH: go to DONE with error_o = 1.
    - Otherwise: latch the count, set address to 0 and byte index to 0, go to COLLECT.
- COLLECT:
  - byte_ready_o = 1, busy_o = 1.
  - Each transfer stores byte_i at bits [8k+7:8k] of the word register, where k is the byte index (0..DATA_WIDTH/8-1), then increments k.
  - Idle cycles (valid = 0) change nothing.
  - On the transfer of the last byte (k = DATA_WIDTH/8-1), go to WRITE.
- WRITE (exactly one cycle):
  - mem_we_o = 1, mem_addr_o = current address, mem_data_o = assembled word; byte_ready_o = 0.
  - If address == count-1, go to DONE.
  - Otherwise increment the address, clear k, and return to COLLECT.
- DONE (one cycle):
  - done_o = 1, busy_o = 0, byte_ready_o = 0; error_o holds the value set on entry.
  - Next state is IDLE.
  - error_o is 0 in every other state.
- mem_addr_o and mem_data_o hold their last values when mem_we_o = 0.
- Address never wraps. A full-depth load (count = 2^ADDR_WIDTH) ends after the write to address 2^ADDR_WIDTH-1. No write to address 0 follows it.
- start_i is ignored outside IDLE.
- byte_i is ignored when byte_ready_o = 0; the producer must hold that byte.
- Timing:
  - byte_ready_o rises one cycle after start is sampled.
  - Minimum throughput is DATA_WIDTH/8 + 1 cycles per word.
  - The last write is followed, one cycle later, by the done_o cycle.
- Reset mid-load aborts the load: no further writes, and no done pulse for the aborted load. Words already written remain in memory.

Decomposition:
- Shared package/include: state encodings (IDLE, COLLECT, WRITE, DONE) and the constant BYTES_PER_WORD = DATA_WIDTH/8.
- One natural sub-module, byte_word_assembler: byte-index counter plus word register. It takes byte, strobe and clear inputs and provides word and last-byte outputs.
- The FSM and address counter stay in program_memory_loader.

Test Plan:
1. Reset, then start with count = 2, bytes 78 56 34 12 EF BE AD DE back-to-back -> write (addr 0, 0x12345678), then write (addr 1, 0xDEADBEEF); done_o pulses the cycle after the second write, error_o = 0; 11 cycles from the first ready to done.
2. Same stream with byte_valid_i low for 3 cycles between every byte -> identical writes and data, only later; exactly 2 mem_we_o pulses.
3. start with count = 0 -> done_o = 1, error_o = 0 one cycle after start; no mem_we_o; byte_ready_o stays 0.
4. start with count = 257 (ADDR_WIDTH = 8) -> done_o = 1, error_o = 1; no writes. A following valid start loads normally with error_o = 0.
5. Load count = 1; assert reset after 2 bytes are accepted -> no mem_we_o; all outputs 0 the next cycle. A subsequent start with 4 bytes writes addr 0 with only the new bytes.
6. Full-depth count = 256 with a random stream, plus start_i pulsed while busy -> 256 writes at addresses 0..255 in order, data matches the stream; the extra start is ignored; exactly one done_o, with no write after address 255.

Source files
------------

// File: rtl/program_memory_loader_pkg.sv
// rtl/program_memory_loader_pkg.sv - shared state encoding and word geometry helpers
package program_memory_loader_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_WRITE   = 2'd2,
      S_DONE    = 2'd3
   } state_e;

   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / 8;

   function automatic int bytes_per_word(input int data_width);
      return data_width / 8;
   endfunction

   function automatic int index_width(input int bytes);
      return (bytes > 1) ? $clog2(bytes) : 1;
   endfunction

endpackage

// File: rtl/program_memory_loader_byte_word_assembler.sv
// rtl/program_memory_loader_byte_word_assembler.sv - little-endian byte packer with byte-index counter
import program_memory_loader_pkg::*;

module program_memory_loader_byte_word_assembler #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear_i,
   input  logic                  strobe_i,
   input  logic [7:0]            byte_i,
   output logic [DATA_WIDTH-1:0] word_o,
   output logic                  last_o
);

   localparam int BPW   = bytes_per_word(DATA_WIDTH);
   localparam int IDX_W = index_width(BPW);

   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [DATA_WIDTH-1:0] word_q, word_d;

   assign last_o = (idx_q == IDX_W'(BPW - 1));

   always_comb begin
      idx_d  = idx_q;
      word_d = word_q;
      if (clear_i) begin
         idx_d = '0;
      end else if (strobe_i) begin
         word_d[{idx_q, 3'b000} +: 8] = byte_i;
         idx_d = last_o ? '0 : idx_q + 1'b1;
      end
   end

   // word_o already contains the byte being strobed, so the caller can
   // register a complete word on the same edge that accepts the last byte.
   assign word_o = word_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q  <= '0;
         word_q <= '0;
      end else begin
         idx_q  <= idx_d;
         word_q <= word_d;
      end
   end

endmodule

// File: rtl/program_memory_loader.sv
// rtl/program_memory_loader.sv - loads instruction memory from a byte stream, one word per write pulse
import program_memory_loader_pkg::*;

module program_memory_loader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH:0]   word_count_i,
   input  logic [7:0]            byte_i,
   input  logic                  byte_valid_i,
   output logic                  byte_ready_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_data_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  error_o
);

   localparam logic [ADDR_WIDTH:0] MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

   state_e                state_q, state_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
   logic                  byte_ready_q, byte_ready_d;
   logic                  mem_we_q, mem_we_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;

   logic                  asm_clear;
   logic                  asm_strobe;
   logic                  asm_last;
   logic [DATA_WIDTH-1:0] asm_word;

   program_memory_loader_byte_word_assembler #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_assembler (
      .clk      (clk),
      .reset    (reset),
      .clear_i  (asm_clear),
      .strobe_i (asm_strobe),
      .byte_i   (byte_i),
      .word_o   (asm_word),
      .last_o   (asm_last)
   );

   assign asm_strobe = (state_q == S_COLLECT) && byte_valid_i && byte_ready_q;

   // Outputs are computed for the state being entered, so every output is a flop.
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      addr_d       = addr_q;
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;
      byte_ready_d = byte_ready_q;
      mem_we_d     = 1'b0;
      busy_d       = busy_q;
      done_d       = 1'b0;
      error_d      = 1'b0;
      asm_clear    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (word_count_i == '0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else if (word_count_i > MAX_COUNT) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  error_d = 1'b1;
               end else begin
                  state_d      = S_COLLECT;
                  count_d      = word_count_i;
                  addr_d       = '0;
                  asm_clear    = 1'b1;
                  byte_ready_d = 1'b1;
                  busy_d       = 1'b1;
               end
            end
         end
         S_COLLECT: begin
            if (asm_strobe && asm_last) begin
               state_d      = S_WRITE;
               byte_ready_d = 1'b0;
               mem_we_d     = 1'b1;
               mem_addr_d   = addr_q;
               mem_data_d   = asm_word;
            end
         end
         S_WRITE: begin
            // Compared at full count width so a full-depth load ends at the top address.
            if ({1'b0, addr_q} == count_q - 1'b1) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               state_d      = S_COLLECT;
               addr_d       = addr_q + 1'b1;
               asm_clear    = 1'b1;
               byte_ready_d = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         count_q      <= '0;
         addr_q       <= '0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         byte_ready_q <= 1'b0;
         mem_we_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         addr_q       <= addr_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
         byte_ready_q <= byte_ready_d;
         mem_we_q     <= mem_we_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         error_q      <= error_d;
      end
   end

   assign byte_ready_o = byte_ready_q;
   assign mem_we_o     = mem_we_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_data_o   = mem_data_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign error_o      = error_q;

endmodule
